// File: rtl/witf.sv
// witf -- write-in-flight table.
//
// In-order FIFO of destination registers for instructions dispatched by
// decode and not yet written back. Decode pushes rd on dispatch and checks
// rs1/rs2 against every valid entry for RAW hazards. Write-back retires the
// head entry and reports the rd it wrote, which is checked against the head.
//
// Optional feature (macro WITF_BYPASS_EN): the head entry is left out of the
// hazard compare in the cycle it retires. This lets decode issue in the same
// cycle the register is written, and needs a write-first register file.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous reset, active low
//   rs1, rs2    in   decode source register indices
//   isRAW       out  a nonzero source matches a valid in-flight rd (comb)
//   witf_full   out  count == DEPTH
//   witf_empty  out  count == 0
//   disp_en     in   push request from decode (already gated)
//   rd          in   destination register to push
//   retire_en   in   write-back retires the oldest entry
//   retire_rd   in   rd written by write-back
//   count       out  current occupancy
//   retire_err  out  sticky: retire while empty, or retire_rd != head rd

// Hazard compare for one entry; x0 never matches.
module witf_cmp (
  input  logic       v,
  input  logic [4:0] ent,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       hit
);
  assign hit = v && (((rs1 != 5'd0) && (rs1 == ent)) ||
                     ((rs2 != 5'd0) && (rs2 == ent)));
endmodule

module witf #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4:0]     rs1,
  input  logic [4:0]     rs2,
  output logic           isRAW,
  output logic           witf_full,
  output logic           witf_empty,
  input  logic           disp_en,
  input  logic [4:0]     rd,
  input  logic           retire_en,
  input  logic [4:0]     retire_rd,
  output logic [PTR_W:0] count,
  output logic           retire_err
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0][4:0] ent_rd;
  logic [DEPTH-1:0]      ent_v;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DEPTH-1:0]      hit;
  logic [DEPTH-1:0]      excl;
  logic                  push;
  logic                  pop;

  assign witf_full  = (count == FULL_CNT);
  assign witf_empty = (count == '0);

  // Full/empty come from the current count, so a push on a full table and a
  // pop on an empty one are dropped even when the other side fires too.
  assign push = disp_en && !witf_full;
  assign pop  = retire_en && !witf_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_rd     <= '0;
      ent_v      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      retire_err <= 1'b0;
    end else begin
      // wr_ptr == rd_ptr only when empty or full, and push/pop cannot both
      // fire then, so the set and clear below never hit the same slot.
      if (push) begin
        ent_rd[wr_ptr] <= rd;
        ent_v[wr_ptr]  <= 1'b1;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        ent_v[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (retire_en && (witf_empty || (retire_rd != ent_rd[rd_ptr])))
        retire_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    witf_cmp u_cmp (
      .v   (ent_v[i]),
      .ent (ent_rd[i]),
      .rs1 (rs1),
      .rs2 (rs2),
      .hit (hit[i])
    );
  end

  always_comb begin
    excl = '0;
`ifdef WITF_BYPASS_EN
    // Retiring head is being written this cycle; write-first RF forwards it.
    if (pop) excl[rd_ptr] = 1'b1;
`endif
  end

  assign isRAW = |(hit & ~excl);

endmodule

// File: doc/witf.md
Name: witf

Overview:
- Write-in-flight table: an in-order FIFO of destination registers for instructions dispatched from decode and not yet written back.
- Decode pushes `rd` on dispatch and queries RAW hazards for `rs1`/`rs2` against every valid entry.
- Write-back retires the head entry.
- Sits between the decode stage (dispatch/hazard side) and the write-back stage (retire side).

Parameters:
- DEPTH, 4, number of in-flight entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- rs1  input  5  decode source register 1 index.
- rs2  input  5  decode source register 2 index.
- isRAW  output  1  combinational: a source register matches an in-flight rd.
- witf_full  output  1  registered-state derived: count==DEPTH.
- witf_empty  output  1  count==0.
- disp_en  input  1  push request from decode (already gated: rd!=0, handshake done, no flush).
- rd  input  5  destination register to push.
- retire_en  input  1  write-back completes the oldest in-flight writer.
- retire_rd  input  5  rd written by write-back; checked against the head entry.
- count  output  PTR_W+1  current occupancy.
- retire_err  output  1  sticky: retire with empty table or retire_rd≠head rd.

Behaviour:
- State: entry array `ent_rd[DEPTH]` and `ent_v[DEPTH]`, `wr_ptr` and `rd_ptr` (PTR_W bits, wrap modulo DEPTH), `count`, sticky `retire_err`.
- Reset (rst=0, async): all `ent_v`=0, both pointers 0, count=0, retire_err=0.
  - Outputs in reset: witf_empty=1, witf_full=0, isRAW=0.
  - Reset mid-operation discards all entries immediately.
- Push:
  - Condition: disp_en && !witf_full.
  - Writes rd at wr_ptr, sets ent_v, wr_ptr+1.
  - disp_en while full is ignored (no state change). Decode never does this because it stalls on witf_full.
- Pop:
  - Condition: retire_en && !witf_empty.
  - Clears ent_v at rd_ptr, rd_ptr+1.
  - retire_en while empty: no state change, retire_err←1.
  - Pop with retire_rd≠ent_rd[rd_ptr]: pop still happens, retire_err←1.
- Simultaneous push+pop:
  - Both take effect; count unchanged.
  - When full: push is blocked because witf_full comes from current count, so only the pop happens; count−1.
  - When empty: only the push happens; retire_err←1.
- count update: +1 on push only, −1 on pop only, else hold. Count never exceeds DEPTH and never goes below 0.
- isRAW (combinational):
  - OR over all i of ent_v[i] && ((rs1!=0 && rs1==ent_rd[i]) || (rs2!=0 && rs2==ent_rd[i])).
  - x0 never hazards.
  - The entry being pushed in the current cycle is not visible until the next cycle.
  - Without the optional feature, an entry being popped this cycle still counts: conservative, one extra stall cycle.
- Latency:
  - Push is visible to isRAW/count/full one cycle after the push edge.
  - Pop is visible one cycle after the pop edge.
- Duplicate rd values may coexist; the hazard holds until all matching entries retire.

Optional Feature:
- Macro: WITF_BYPASS_EN.
- Defined:
  - When retire_en && !witf_empty, the head entry is excluded from the isRAW compare in that cycle.
  - Decode can issue in the same cycle write-back writes the register.
  - Requires the register file to be write-first (read returns the value being written).
- Undefined: no exclusion; the head entry hazards until its pop edge.

Test Plan:
- Reset, then push rd=5, next cycle rs1=5, rs2=0 → isRAW=1, count=1, witf_empty=0; rs1=0, rs2=0 → isRAW=0.
- Push rd=1,2,3,4 on consecutive cycles (DEPTH=4) → witf_full=1, count=4; fifth push rd=6 ignored, then rs2=6 → isRAW=0.
- Full table, assert disp_en(rd=7) and retire_en(retire_rd=1) together → count=3, rs1=7 → isRAW=0, head now rd=2.
- Push rd=9, then retire_en with retire_rd=9 while rs1=9:
  - Without WITF_BYPASS_EN → isRAW=1 that cycle, 0 next.
  - With it → isRAW=0 that cycle.
- retire_en with table empty → retire_err=1 and stays 1 after later valid traffic; retire_rd=3 while head=8 → retire_err=1, pop still occurs.
- Fill 3 entries, drop rst low asynchronously mid-cycle → witf_empty=1, count=0, isRAW=0 immediately; pointers wrap correctly after 6 push/pop pairs (rd visible at correct index).
